dcache_refill_controller: RTL

//   Drives the write port of the D-cache register array. On a miss, fetches one

---
 rtl/dcache_refill_controller_if.sv | 44 ++++
 rtl/dcache_refill_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dcache_refill_controller_if.sv
// Bus bundle between the D-cache refill controller, the miss/store logic, memory and the array.
interface dcache_refill_controller_if #(
  parameter int unsigned double_word_offset_width = 3,
  parameter int unsigned line_width               = 6
);
  localparam int unsigned TagWidth  = 32 - double_word_offset_width - 3 - line_width;
  localparam int unsigned BlockSize = 1 << double_word_offset_width;

  logic                    miss_valid;
  logic                    miss_ready;
  logic [31:0]             miss_address;
  logic                    store_valid;
  logic                    store_ready;
  logic [31:0]             store_address;
  logic [63:0]             store_data;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [31:0]             mem_req_address;
  logic                    mem_resp_valid;
  logic                    mem_resp_ready;
  logic [63:0]             mem_resp_data;
  logic                    write_in;
  logic [line_width-1:0]   write_line_index;
  logic [64*BlockSize-1:0] write_block;
  logic [TagWidth-1:0]     write_tag;
  logic [BlockSize-1:0]    write_mask;
  logic                    refill_done;

  // Controller side.
  modport master (
    input  miss_valid, miss_address, store_valid, store_address, store_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, store_ready, mem_req_valid, mem_req_address, mem_resp_ready,
           write_in, write_line_index, write_block, write_tag, write_mask, refill_done
  );

  // Environment side (miss/store logic, memory, register array).
  modport slave (
    output miss_valid, miss_address, store_valid, store_address, store_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, store_ready, mem_req_valid, mem_req_address, mem_resp_ready,
           write_in, write_line_index, write_block, write_tag, write_mask, refill_done
  );
endinterface

// File: rtl/dcache_refill_controller.sv
// D-cache write-port controller: block refills from memory and store-hit double-word writes.
module dcache_refill_controller #(
  parameter int unsigned double_word_offset_width = 3,
  parameter int unsigned line_width               = 6
) (
  input logic                        clock,
  input logic                        reset,
  dcache_refill_controller_if.master bus_io
);
  localparam int unsigned Dwo       = double_word_offset_width;
  localparam int unsigned OffWidth  = Dwo + 3;
  localparam int unsigned TagWidth  = 32 - OffWidth - line_width;
  localparam int unsigned BlkWidth  = TagWidth + line_width;
  localparam int unsigned BlockSize = 1 << Dwo;

  typedef enum logic [1:0] {StIdle, StReq, StFill, StCommit} state_e;

  state_e                state_q, state_d;
  logic [Dwo-1:0]        count_q, count_d;
  logic [BlkWidth-1:0]   blk_q, blk_d;  // {tag, line} of the block being refilled
  logic [63:0]           fill_q [BlockSize];
  logic [63:0]           fill_d [BlockSize];
  logic                  req_valid_q, req_valid_d;
  logic                  resp_ready_q, resp_ready_d;
  logic                  write_in_q, write_in_d;
  logic                  refill_done_q, refill_done_d;
  logic [BlockSize-1:0]  write_mask_q, write_mask_d;
  logic [63:0]           write_block_q [BlockSize];
  logic [63:0]           write_block_d [BlockSize];
  logic [TagWidth-1:0]   write_tag_q, write_tag_d;
  logic [line_width-1:0] write_line_q, write_line_d;
  logic                  idle, store_hs;
  logic [Dwo-1:0]        store_slot;
  logic                  unused_addr_bits;

  assign idle       = (state_q == StIdle);
  // A pending miss always wins over a store in the same cycle.
  assign store_hs   = bus_io.store_valid & idle & ~bus_io.miss_valid;
  assign store_slot = bus_io.store_address[OffWidth-1:3];
  assign unused_addr_bits = ^{bus_io.miss_address[OffWidth-1:0], bus_io.store_address[2:0]};

  assign bus_io.miss_ready       = idle;
  assign bus_io.store_ready      = idle & ~bus_io.miss_valid;
  assign bus_io.mem_req_valid    = req_valid_q;
  assign bus_io.mem_req_address  = {blk_q, OffWidth'(0)};
  assign bus_io.mem_resp_ready   = resp_ready_q;
  assign bus_io.write_in         = write_in_q;
  assign bus_io.write_line_index = write_line_q;
  assign bus_io.write_tag        = write_tag_q;
  assign bus_io.write_mask       = write_mask_q;
  assign bus_io.refill_done      = refill_done_q;

  for (genvar j = 0; j < BlockSize; j++) begin : g_pack
    assign bus_io.write_block[64*j +: 64] = write_block_q[j];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    blk_d         = blk_q;
    fill_d        = fill_q;
    write_in_d    = 1'b0;
    refill_done_d = 1'b0;
    write_mask_d  = write_mask_q;
    write_block_d = write_block_q;
    write_tag_d   = write_tag_q;
    write_line_d  = write_line_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.miss_valid) begin
          blk_d   = bus_io.miss_address[31:OffWidth];
          state_d = StReq;
        end else if (store_hs) begin
          write_in_d                = 1'b1;
          write_mask_d              = '0;
          write_mask_d[store_slot]  = 1'b1;
          write_block_d[store_slot] = bus_io.store_data;
          write_tag_d  = bus_io.store_address[31:32-TagWidth];
          write_line_d = bus_io.store_address[line_width+OffWidth-1:OffWidth];
        end
      end
      StReq: begin
        if (bus_io.mem_req_ready) begin
          count_d = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (bus_io.mem_resp_valid) begin
          fill_d[count_q] = bus_io.mem_resp_data;
          if (count_q == Dwo'(BlockSize - 1)) begin
            // Last beat: the assembled block lands on the write port next cycle.
            state_d       = StCommit;
            write_in_d    = 1'b1;
            refill_done_d = 1'b1;
            write_mask_d  = '1;
            write_block_d = fill_d;
            write_tag_d   = blk_q[BlkWidth-1:line_width];
            write_line_d  = blk_q[line_width-1:0];
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StCommit: begin
        count_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    req_valid_d  = (state_d == StReq);
    resp_ready_d = (state_d == StFill);
  end

  // Control and write-port registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      blk_q         <= '0;
      req_valid_q   <= 1'b0;
      resp_ready_q  <= 1'b0;
      write_in_q    <= 1'b0;
      refill_done_q <= 1'b0;
      write_mask_q  <= '0;
      write_block_q <= '{default: '0};
      write_tag_q   <= '0;
      write_line_q  <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      blk_q         <= blk_d;
      req_valid_q   <= req_valid_d;
      resp_ready_q  <= resp_ready_d;
      write_in_q    <= write_in_d;
      refill_done_q <= refill_done_d;
      write_mask_q  <= write_mask_d;
      write_block_q <= write_block_d;
      write_tag_q   <= write_tag_d;
      write_line_q  <= write_line_d;
    end
  end

  // Beat assembly buffer; every slot is rewritten before it is ever committed.
  always_ff @(posedge clock) begin
    fill_q <= fill_d;
  end
endmodule
